// File: rtl/nrisc_regfile_sb.sv
// NRISC register file: 2 async read ports, 1 sync write port, pending-write scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining NRISC_RF_BYPASS_EN.
module nrisc_regfile_sb #(
    parameter int TAM     = 16,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       ra_addr,
    output logic [TAM-1:0]      ra_data,
    output logic                ra_busy,
    input  logic [AW-1:0]       rb_addr,
    output logic [TAM-1:0]      rb_data,
    output logic                rb_busy,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [TAM-1:0]      wr_data,
    output logic [(2**AW)-1:0]  pend
);

    localparam int   NREG = 2 ** AW;
    localparam logic ZR   = (ZERO_R0 != 0);

    logic [TAM-1:0]  regs_r [NREG];
    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;
    logic            wr_ok_s;
    logic            rsv_ready_s;
    logic            ra_zero_s;
    logic            rb_zero_s;
    logic            ra_hit_s;
    logic            rb_hit_s;

    // Write qualification and reservation acceptance
    always_comb begin
        wr_ok_s     = wr_en & ~(ZR & (wr_addr == {AW{1'b0}}));
        rsv_ready_s = ~pend_r[rsv_addr]
                    | (wr_en & (wr_addr == rsv_addr))
                    | (ZR & (rsv_addr == {AW{1'b0}}));
    end

    // Next pending vector: write clears, accepted reservation sets (set wins)
    always_comb begin
        pend_nxt_s = pend_r;
        if (wr_ok_s) begin
            pend_nxt_s[wr_addr] = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
        if (rsv_valid && rsv_ready_s) begin
            pend_nxt_s[rsv_addr] = 1'b1;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (ZR) begin
            pend_nxt_s[0] = 1'b0;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // Register array and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {TAM{1'b0}};
            end
            pend_r <= {NREG{1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_r[wr_addr] <= wr_data;
            end else begin
                regs_r[wr_addr] <= regs_r[wr_addr];
            end
            pend_r <= pend_nxt_s;
        end
    end

    // Read ports; a bypass hit forwards writeback data and hides the pending bit
    always_comb begin
        ra_zero_s = ZR & (ra_addr == {AW{1'b0}});
        rb_zero_s = ZR & (rb_addr == {AW{1'b0}});
`ifdef NRISC_RF_BYPASS_EN
        ra_hit_s  = wr_en & (wr_addr == ra_addr) & ~ra_zero_s;
        rb_hit_s  = wr_en & (wr_addr == rb_addr) & ~rb_zero_s;
`else
        ra_hit_s  = 1'b0;
        rb_hit_s  = 1'b0;
`endif
        if (ra_zero_s) begin
            ra_data = {TAM{1'b0}};
        end else if (ra_hit_s) begin
            ra_data = wr_data;
        end else begin
            ra_data = regs_r[ra_addr];
        end
        if (rb_zero_s) begin
            rb_data = {TAM{1'b0}};
        end else if (rb_hit_s) begin
            rb_data = wr_data;
        end else begin
            rb_data = regs_r[rb_addr];
        end
        ra_busy = pend_r[ra_addr] & ~ra_hit_s;
        rb_busy = pend_r[rb_addr] & ~rb_hit_s;
    end

    assign rsv_ready = rsv_ready_s;
    assign pend      = pend_r;

endmodule

// File: tb/tb_nrisc_regfile_sb.sv
// Scoreboard bench for nrisc_regfile_sb: default instance plus a ZERO_R0=1 instance on shared stimulus.
module tb_nrisc_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra_addr, rb_addr, rsv_addr, wr_addr;
    logic        rsv_valid, wr_en;
    logic [15:0] wr_data;

    logic [15:0] ra_data, rb_data, z_ra_data, z_rb_data;
    logic        ra_busy, rb_busy, z_ra_busy, z_rb_busy;
    logic        rsv_ready, z_rsv_ready;
    logic [15:0] pend, z_pend;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] mdl [16];

    always #5 clk = ~clk;

    nrisc_regfile_sb #(.TAM(16), .AW(4), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend(pend)
    );

    nrisc_regfile_sb #(.TAM(16), .AW(4), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(z_ra_data), .ra_busy(z_ra_busy),
        .rb_addr(rb_addr), .rb_data(z_rb_data), .rb_busy(z_rb_busy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(z_rsv_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend(z_pend)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check_value("sb_underflow", 32'd1, 32'd0);
        end else begin
            check_value(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rsv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        // Reset dominates a concurrent write and reservation
        rst = 1'b1; ra_addr = 4'd3; rb_addr = 4'd0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        rsv_valid = 1'b1; rsv_addr = 4'd3;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0; idle();
        sb_push("rst_ra_data", 32'h0); sb_push("rst_rb_data", 32'h0);
        sb_push("rst_pend", 32'h0); sb_push("rst_ra_busy", 32'h0);
        sb_push("rst_z_pend", 32'h0);
        #1;
        sb_pop(ra_data); sb_pop(rb_data); sb_pop(pend); sb_pop(ra_busy); sb_pop(z_pend);

        // Write r5, read on both ports next cycle; others stay zero
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        tick(); idle(); mdl[5] = 16'h1234;
        ra_addr = 4'd5; rb_addr = 4'd5;
        sb_push("r5_ra", 32'h1234); sb_push("r5_rb", 32'h1234);
        #1; sb_pop(ra_data); sb_pop(rb_data);
        for (int i = 0; i < 16; i++) begin
            ra_addr = 4'(i);
            sb_push("scan_ra", {16'h0, mdl[i]});
            #1; sb_pop(ra_data);
        end

        // Reserve r7, blocked re-reservation, write clears pending
        rsv_valid = 1'b1; rsv_addr = 4'd7;
        sb_push("r7_rdy", 32'h1); #1; sb_pop(rsv_ready);
        tick(); idle(); ra_addr = 4'd7;
        sb_push("r7_pend", 32'h0080); sb_push("r7_busy", 32'h1);
        #1; sb_pop(pend); sb_pop(ra_busy);
        rsv_valid = 1'b1;
        sb_push("r7_rdy_blocked", 32'h0); #1; sb_pop(rsv_ready);
        tick(); idle();
        sb_push("r7_pend_hold", 32'h0080); #1; sb_pop(pend);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
        tick(); idle(); mdl[7] = 16'h00AA;
        sb_push("r7_pend_clr", 32'h0); sb_push("r7_data", 32'h00AA); sb_push("r7_busy_clr", 32'h0);
        #1; sb_pop(pend); sb_pop(ra_data); sb_pop(ra_busy);

        // Same-cycle reservation and write to pending r2: reservation wins
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        tick(); idle();
        sb_push("r2_pend", 32'h0004); #1; sb_pop(pend);
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
        sb_push("r2_rdy_wr", 32'h1); #1; sb_pop(rsv_ready);
        tick(); idle(); mdl[2] = 16'h5555; ra_addr = 4'd2;
        sb_push("r2_pend_kept", 32'h0004); sb_push("r2_data", 32'h5555);
        #1; sb_pop(pend); sb_pop(ra_data);
        // Different addresses act independently
        rsv_valid = 1'b1; rsv_addr = 4'd4;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h6666;
        tick(); idle(); mdl[2] = 16'h6666;
        sb_push("r4_r2_pend", 32'h0010); sb_push("r2_data2", 32'h6666);
        #1; sb_pop(pend); sb_pop(ra_data);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0444;
        tick(); idle(); mdl[4] = 16'h0444;

        // Register 0: hardwired zero on ZERO_R0 instance, ordinary on default
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rsv_valid = 1'b1; rsv_addr = 4'd0;
        sb_push("z_r0_rdy", 32'h1); #1; sb_pop(z_rsv_ready);
        tick(); idle(); mdl[0] = 16'hFFFF; ra_addr = 4'd0; rb_addr = 4'd0;
        sb_push("z_r0_ra", 32'h0); sb_push("z_r0_rb", 32'h0); sb_push("z_pend", 32'h0);
        sb_push("z_r0_busy", 32'h0);
        sb_push("d_r0_ra", 32'hFFFF); sb_push("d_pend_r0", 32'h0001);
        #1; sb_pop(z_ra_data); sb_pop(z_rb_data); sb_pop(z_pend); sb_pop(z_ra_busy);
        sb_pop(ra_data); sb_pop(pend);
        rsv_valid = 1'b1; rsv_addr = 4'd0;
        sb_push("z_r0_rdy_again", 32'h1); sb_push("d_r0_rdy_blocked", 32'h0);
        #1; sb_pop(z_rsv_ready); sb_pop(rsv_ready);
        idle();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
        tick(); idle(); mdl[0] = 16'h0000;
        sb_push("d_pend_r0_clr", 32'h0); #1; sb_pop(pend);

        // Writeback to a pending register observed on the read ports in the write cycle
        rsv_valid = 1'b1; rsv_addr = 4'd9;
        tick(); idle();
        ra_addr = 4'd9; rb_addr = 4'd9;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hC0DE;
`ifdef NRISC_RF_BYPASS_EN
        sb_push("r9_byp_ra", 32'hC0DE); sb_push("r9_byp_busy", 32'h0);
        sb_push("r9_byp_rb", 32'hC0DE); sb_push("r9_byp_rbbusy", 32'h0);
`else
        sb_push("r9_old_ra", 32'h0); sb_push("r9_old_busy", 32'h1);
        sb_push("r9_old_rb", 32'h0); sb_push("r9_old_rbbusy", 32'h1);
`endif
        #1; sb_pop(ra_data); sb_pop(ra_busy); sb_pop(rb_data); sb_pop(rb_busy);
        tick(); idle(); mdl[9] = 16'hC0DE;
        sb_push("r9_after", 32'hC0DE); sb_push("r9_busy_after", 32'h0); sb_push("r9_pend_after", 32'h0);
        #1; sb_pop(ra_data); sb_pop(ra_busy); sb_pop(pend);

        // Random writes followed by dual-port reads against the storage model
        for (int n = 0; n < 24; n++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 16'($urandom);
            tick(); idle(); mdl[wr_addr] = wr_data;
            ra_addr = 4'($urandom_range(0, 15)); rb_addr = 4'($urandom_range(0, 15));
            sb_push("rnd_ra", {16'h0, mdl[ra_addr]});
            sb_push("rnd_rb", {16'h0, mdl[rb_addr]});
            sb_push("rnd_z_ra", (ra_addr == 4'd0) ? 32'h0 : {16'h0, mdl[ra_addr]});
            #1; sb_pop(ra_data); sb_pop(rb_data); sb_pop(z_ra_data);
        end
        sb_push("final_pend", 32'h0); #1; sb_pop(pend);

        if (exp_q.size() != 0) check_value("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
